prbs7_checker: RTL and testbench
================================

PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16: consecutive correctly predicted bits required to declare lock (range 1..255).
REQ-002 SHALL have parameter LOSS_CNT, default 8: consecutive errored bits while locked that force loss of lock (range 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_bit is a stream bit this cycle.
REQ-006 SHALL have port in_bit  input  1  serial received data bit.
REQ-007 SHALL have port clear_cnt  input  1  synchronous clear of err_count.
REQ-008 SHALL have port locked  output  1  checker synchronised to the PRBS7 stream.
REQ-009 SHALL have port err_pulse  output  1  one-cycle strobe for a mismatched bit while locked.
REQ-010 SHALL have port err_count  output  16  saturating count of mismatched bits while locked.

Function
REQ-011 SHALL check PRBS7 with XNOR feedback (x^7+x^6+1) using a 7-bit state s and prediction p = ~(s[6] ^ s[5]).
REQ-012 SHALL implement FSM states SEED, VERIFY and LOCKED.
REQ-013 SHALL leave state, s, counters and outputs unchanged on cycles with in_valid=0, and SHALL drive err_pulse=0 on those cycles.
REQ-014 SEED SHALL do s <= {s[5:0], in_bit} per valid bit and go to VERIFY after the 7th valid bit, unless the resulting s = 7'h7F (XNOR lock-up), in which case it stays in SEED and restarts the 7-bit fill count.
REQ-015 VERIFY SHALL do s <= {s[5:0], in_bit} per valid bit (self-synchronising).
REQ-016 VERIFY SHALL count consecutive in_bit == p matches, go to LOCKED on the LOCK_CNT-th match, and on any mismatch return to SEED with all counters zeroed.
REQ-017 LOCKED SHALL free-run s <= {s[5:0], p} per valid bit, independent of in_bit.
REQ-018 LOCKED SHALL, on in_bit != p, assert err_pulse for exactly one cycle (the cycle after the bit) and increment err_count, saturating at 16'hFFFF.
REQ-019 LOCKED SHALL increment a consecutive-error counter per mismatch and zero it on a match.
REQ-020 LOCKED SHALL go to SEED when the consecutive-error counter reaches LOSS_CNT, dropping locked on the same edge; err_count SHALL retain its value.
REQ-021 locked SHALL be registered: 1 exactly when state is LOCKED, rising on the edge that samples the LOCK_CNT-th VERIFY match.
REQ-022 clear_cnt=1 SHALL zero err_count and SHALL take priority over a simultaneous increment (result 0); it SHALL NOT affect FSM state or lock.
REQ-023 Mismatches in SEED or VERIFY SHALL NOT pulse err_pulse or change err_count.

Reset
REQ-024 rst=1 SHALL, at the next rising edge, set state=SEED, s=7'h00, fill, match and error counters=0, locked=0, err_pulse=0 and err_count=0, with priority over all other inputs.
REQ-025 rst asserted mid-lock SHALL discard synchronisation; re-acquisition SHALL require the full 7+LOCK_CNT valid bits.

Configuration
REQ-026 With macro PRBS7_CHECKER_BITCNT_EN defined, the block SHALL add output bit_count (32 bits), counting valid bits checked while LOCKED, wrapping FFFFFFFF->0, reset to 0, and cleared by clear_cnt.
REQ-027 Without PRBS7_CHECKER_BITCNT_EN, the bit_count port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Scenario: reset, then 23 valid clean PRBS7 bits from seed 7'h01 -> locked=1 on the cycle after bit 23, err_count=0.
REQ-029 Scenario: while locked, one inverted bit -> err_pulse high for exactly 1 cycle, err_count=1, locked stays 1.
REQ-030 Scenario: while locked, 8 consecutive inverted bits -> err_count=8, locked=0 after the 8th bit; clean stream -> relock after 23 further bits.
REQ-031 Scenario: 40 valid all-ones bits after reset -> locked stays 0, err_pulse never asserts.
REQ-032 Scenario: locked with err_count=5, clear_cnt=1 in the same cycle as an errored bit -> err_count=0 next cycle; rst mid-lock -> locked=0, err_count=0 next cycle.
REQ-033 Scenario: clean stream with in_valid toggling 1,0,0,1 -> lock timing counted in valid bits only, no spurious errors; with PRBS7_CHECKER_BITCNT_EN, bit_count equals valid bits since lock.

Source files
------------

// File: rtl/prbs7_checker.sv
// prbs7_checker: serial PRBS7 checker (x^7+x^6+1, XNOR) with SEED/VERIFY/LOCKED FSM.
// Optional macro PRBS7_CHECKER_BITCNT_EN adds a 32-bit count of bits checked while locked.
module prbs7_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        clear_cnt,
`ifdef PRBS7_CHECKER_BITCNT_EN
    output logic [31:0] bit_count,
`endif
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [7:0] LOSS_LAST = 8'(LOSS_CNT - 1);

    state_t      state_q, state_d;
    logic [6:0]  s_q, s_d;
    logic [2:0]  fill_q, fill_d;
    logic [7:0]  match_q, match_d;
    logic [7:0]  errs_q, errs_d;
    logic        locked_q, locked_d;
    logic        pulse_q, pulse_d;
    logic [15:0] cnt_q, cnt_d;

    logic        pred;
    logic [6:0]  s_shift;

    assign pred    = ~(s_q[6] ^ s_q[5]);
    assign s_shift = {s_q[5:0], in_bit};

    // Register bank; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SEED;
            s_q      <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            errs_q   <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            errs_q   <= errs_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: seed the LFSR, verify predictions, then free-run and count errors.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        fill_d   = fill_q;
        match_d  = match_q;
        errs_d   = errs_q;
        locked_d = locked_q;
        pulse_d  = 1'b0;
        cnt_d    = cnt_q;
        if (in_valid) begin
            unique case (state_q)
                ST_SEED: begin
                    s_d = s_shift;
                    if (fill_q == 3'd6) begin
                        fill_d = '0;
                        if (s_shift != 7'h7F) begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                ST_VERIFY: begin
                    s_d = s_shift;
                    if (in_bit == pred) begin
                        if (match_q == LOCK_LAST) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            match_d  = '0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        state_d = ST_SEED;
                        fill_d  = '0;
                        match_d = '0;
                        errs_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    s_d = {s_q[5:0], pred};
                    if (in_bit != pred) begin
                        pulse_d = 1'b1;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        if (errs_q == LOSS_LAST) begin
                            state_d  = ST_SEED;
                            locked_d = 1'b0;
                            errs_d   = '0;
                            fill_d   = '0;
                            match_d  = '0;
                        end else begin
                            errs_d = errs_q + 8'd1;
                        end
                    end else begin
                        errs_d = '0;
                    end
                end
                default: begin
                    state_d  = ST_SEED;
                    locked_d = 1'b0;
                end
            endcase
        end
        if (clear_cnt) begin
            cnt_d = '0;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;

`ifdef PRBS7_CHECKER_BITCNT_EN
    logic [31:0] bits_q;

    // Count valid bits checked while locked; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt) begin
            bits_q <= '0;
        end else if (in_valid && state_q == ST_LOCKED) begin
            bits_q <= bits_q + 32'd1;
        end
    end

    assign bit_count = bits_q;
`endif

endmodule

// File: tb/tb_prbs7_checker.sv
// tb_prbs7_checker: directed stimulus with a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_prbs7_checker;

    localparam int LOCK = 16;
    localparam int LOSS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
`ifdef PRBS7_CHECKER_BITCNT_EN
    logic [31:0] bit_count;
`endif

    prbs7_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear_cnt (clear_cnt),
`ifdef PRBS7_CHECKER_BITCNT_EN
        .bit_count (bit_count),
`endif
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit saw_pulse = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: history queue (index 0 = oldest bit) and plain counters.
    localparam int M_SEED = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;
    int          m_st;
    bit          hist[$];
    int          m_fill, m_match, m_errs, m_cnt;
    logic [31:0] m_bc;
    bit          m_pulse;

    always @(posedge clk) begin
        bit p;
        int ones;
        if (rst) begin
            m_st = M_SEED;
            hist = {};
            repeat (7) hist.push_back(1'b0);
            m_fill = 0;
            m_match = 0;
            m_errs = 0;
            m_cnt = 0;
            m_bc = 0;
            m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (in_valid) begin
                p = !(hist[0] ^ hist[1]);
                void'(hist.pop_front());
                case (m_st)
                    M_SEED: begin
                        hist.push_back(in_bit);
                        m_fill++;
                        if (m_fill == 7) begin
                            m_fill = 0;
                            ones = 0;
                            foreach (hist[i]) ones += int'(hist[i]);
                            if (ones != 7) m_st = M_VERIFY;
                        end
                    end
                    M_VERIFY: begin
                        hist.push_back(in_bit);
                        if (in_bit == p) begin
                            m_match++;
                            if (m_match == LOCK) begin
                                m_st = M_LOCKED;
                                m_match = 0;
                            end
                        end else begin
                            m_st = M_SEED;
                            m_match = 0;
                            m_fill = 0;
                        end
                    end
                    default: begin
                        hist.push_back(p);
                        m_bc = m_bc + 1;
                        if (in_bit != p) begin
                            m_pulse = 1;
                            if (m_cnt < 65535) m_cnt++;
                            m_errs++;
                            if (m_errs == LOSS) begin
                                m_st = M_SEED;
                                m_errs = 0;
                                m_fill = 0;
                            end
                        end else begin
                            m_errs = 0;
                        end
                    end
                endcase
            end
            if (clear_cnt) begin
                m_cnt = 0;
                m_bc = 0;
            end
        end
        #1;
        if (err_pulse === 1'b1) saw_pulse = 1'b1;
        chk("cmp_locked", 32'(locked), 32'(m_st == M_LOCKED));
        chk("cmp_err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("cmp_err_count", 32'(err_count), m_cnt);
`ifdef PRBS7_CHECKER_BITCNT_EN
        chk("cmp_bit_count", bit_count, m_bc);
`endif
    end

    // Stimulus helpers: generator g produces the clean XNOR PRBS7 stream.
    logic [6:0] g = 7'h01;

    task automatic step(input logic v, input logic b, input logic c,
                        input logic r);
        @(negedge clk);
        in_valid = v;
        in_bit = b;
        clear_cnt = c;
        rst = r;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic flip, input logic c);
        logic b;
        b = ~(g[6] ^ g[5]);
        g = {g[5:0], b};
        step(1'b1, b ^ flip, c, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    initial begin
        int nv;
        int k;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_err_pulse", 32'(err_pulse), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);

        // Clean acquisition from generator seed 7'h01.
        repeat (22) send(1'b0, 1'b0);
        chk("lock_not_at_22", 32'(locked), 32'd0);
        send(1'b0, 1'b0);
        chk("lock_at_23", 32'(locked), 32'd1);
        chk("lock_err_count", 32'(err_count), 32'd0);

        // Single inverted bit while locked.
        send(1'b1, 1'b0);
        chk("single_err_pulse", 32'(err_pulse), 32'd1);
        chk("single_err_count", 32'(err_count), 32'd1);
        chk("single_locked", 32'(locked), 32'd1);
        send(1'b0, 1'b0);
        chk("single_pulse_drop", 32'(err_pulse), 32'd0);

        // Burst of LOSS inverted bits drops lock, then relock.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear_idle", 32'(err_count), 32'd0);
        repeat (7) send(1'b1, 1'b0);
        chk("burst7_locked", 32'(locked), 32'd1);
        send(1'b1, 1'b0);
        chk("burst8_unlocked", 32'(locked), 32'd0);
        chk("burst8_err_count", 32'(err_count), 32'd8);
        repeat (22) send(1'b0, 1'b0);
        chk("relock_not_22", 32'(locked), 32'd0);
        send(1'b0, 1'b0);
        chk("relock_23", 32'(locked), 32'd1);
        chk("relock_err_kept", 32'(err_count), 32'd8);

        // Clear colliding with an errored bit, then reset mid-lock.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) begin
            send(1'b1, 1'b0);
            send(1'b0, 1'b0);
        end
        chk("five_err_count", 32'(err_count), 32'd5);
        send(1'b1, 1'b1);
        chk("clr_prio_count", 32'(err_count), 32'd0);
        chk("clr_keeps_lock", 32'(locked), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_mid_locked", 32'(locked), 32'd0);
        chk("rst_mid_count", 32'(err_count), 32'd0);

        // All-ones stream: lock-up seed must never verify.
        saw_pulse = 1'b0;
        repeat (40) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ones_locked", 32'(locked), 32'd0);
        chk("ones_no_pulse", 32'(saw_pulse), 32'd0);

        // Gapped valid pattern 1,0,0,1: lock counted in valid bits only.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        nv = 0;
        k = 0;
        while (nv < 23) begin
            if (pat[k % 4]) begin
                send(1'b0, 1'b0);
                nv++;
                if (nv == 22) chk("gap_not_22", 32'(locked), 32'd0);
            end else begin
                idle();
            end
            k++;
        end
        chk("gap_lock_23", 32'(locked), 32'd1);
        nv = 0;
        while (nv < 10) begin
            if (pat[k % 4]) begin
                send(1'b0, 1'b0);
                nv++;
            end else begin
                idle();
            end
            k++;
        end
        chk("gap_err_count", 32'(err_count), 32'd0);
`ifdef PRBS7_CHECKER_BITCNT_EN
        chk("gap_bit_count", bit_count, 32'd10);
`endif
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
